mult_div_unit: RTL

//  Iterative multiply/divide engine for MULT, MULTU, DIV, DIVU, upstream of the HI/LO register.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mult_div_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS integer pipeline: multiply/divide opcodes, FSM states and width.
// Pure declarations; no latency.
// No flow control of its own.
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine (shift-add multiply, restoring divide) feeding HI/LO.
// Latency: done pulses WIDTH+2 cycles after the accepting edge, independent of operands.
// start is only taken in IDLE; requests while busy or in DONE are dropped, never queued.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t       state, state_nxt;
  mdu_op_t          op_in;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             in_signed, in_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, alu_a, alu_b;
  logic             alu_cin;
  logic [WIDTH+1:0] alu_sum;
  logic [2*WIDTH-1:0] prod_neg;

  assign op_in     = mdu_op_t'(op);
  assign in_signed = (op_in == MDU_MULT) || (op_in == MDU_DIV);
  assign in_div    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
  assign mag_a     = a_neg ? (~a + WIDTH'(1)) : a;
  assign mag_b     = b_neg ? (~b + WIDTH'(1)) : b;

  assign busy      = (state == MDU_RUN) || (state == MDU_FIX);
  assign prod_neg  = ~{acc_hi, acc_lo} + (2*WIDTH)'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = MDU_RUN;
      MDU_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_DONE;
      MDU_DONE: state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  // One adder serves both the multiply accumulate and the divide trial subtract.
  // For divide, carry out of bit WIDTH+1 means no borrow (partial remainder >= divisor).
  always_comb begin
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    if (is_div) begin
      alu_a   = shifted;
      alu_b   = ~{1'b0, opnd};
      alu_cin = 1'b1;
    end else begin
      alu_a   = {1'b0, acc_hi};
      alu_b   = acc_lo[0] ? {1'b0, opnd} : '0;
      alu_cin = 1'b0;
    end
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{(WIDTH+1){1'b0}}, alu_cin};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      done     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            // multiply: opnd = multiplicand, acc_lo = multiplier
            // divide:   opnd = divisor,      acc_lo = dividend
            is_div   <= in_div;
            opnd     <= in_div ? mag_b : mag_a;
            acc_lo   <= in_div ? mag_a : mag_b;
            acc_hi   <= '0;
            cnt      <= '0;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
          end
        end
        MDU_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc_hi <= alu_sum[WIDTH+1] ? alu_sum[WIDTH-1:0] : shifted[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], alu_sum[WIDTH+1]};
          end else begin
            acc_hi <= alu_sum[WIDTH:1];
            acc_lo <= {alu_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        MDU_FIX: begin
          if (is_div) begin
            // Divide by zero leaves |a| as remainder; re-signing it restores the original a.
            if (div_zero)   acc_lo <= '1;
            else if (neg_q) acc_lo <= ~acc_lo + WIDTH'(1);
            if (neg_r)      acc_hi <= ~acc_hi + WIDTH'(1);
          end else if (neg_q) begin
            {acc_hi, acc_lo} <= prod_neg;
          end
        end
        MDU_DONE: begin
          hi_out <= acc_hi;
          lo_out <= acc_lo;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
